signal_decay_sweeper: RTL and testbench

Background engine that ages the pheromone field: on each `start` it raster-scans every cell of the environment grid, reads the cell through the per-row lookup port, decrements its signal by `DECAY_AMOUNT` with saturation at zero, and writes it back through the per-row write port. It sits between the simulation controller and the environment register rows. Its lookup/write address and flag outputs drive the row decoders, and it consumes the rows' lookup data. The pipeline processes one cell per clock and yields the ports to ant traffic whenever `hold` is asserted.

---
 rtl/signal_decay_sweeper.sv | 171 +++++++++++++++++
 tb/tb_signal_decay_sweeper.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_decay_sweeper.sv
// signal_decay_sweeper
//   Background pheromone-decay engine. On start it raster-scans every grid
//   cell and processes one cell per clock. Each cell is read through the lookup
//   port, its signal is decremented by DECAY_AMOUNT (saturating at zero), and
//   the result is written back through the write port one cycle later.
//   While hold is high the engine yields both ports to ant traffic.
//
// Ports
//   newLocClock    system clock
//   RESET_SIM      asynchronous active-high reset
//   start          single-cycle sweep request, sampled only when idle
//   hold           ant logic owns the env ports this cycle
//   busy, done     sweep in progress / one-cycle completion pulse
//   lookup_*       read address, read enable, and combinational read data
//   write_*        write address, write enable, and registered write data

module signal_decay_sweeper #(
  parameter int unsigned PIXELS_X     = 16,
  parameter int unsigned PIXELS_Y     = 16,
  parameter int unsigned X_bits       = 4,
  parameter int unsigned Y_bits       = 4,
  parameter int unsigned SIGNAL_bits  = 4,
  parameter int unsigned DECAY_AMOUNT = 1
) (
  input  logic                   newLocClock,
  input  logic                   RESET_SIM,
  input  logic                   start,
  input  logic                   hold,
  output logic                   busy,
  output logic                   done,
  output logic [X_bits-1:0]      lookup_X,
  output logic [Y_bits-1:0]      lookup_Y,
  output logic                   lookup_en,
  input  logic [SIGNAL_bits-1:0] lookup_signal,
  input  logic                   lookup_sugar,
  output logic [X_bits-1:0]      write_X,
  output logic [Y_bits-1:0]      write_Y,
  output logic                   write_en,
  output logic [SIGNAL_bits-1:0] write_signal,
  output logic                   write_sugar
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [X_bits-1:0] LastX = X_bits'(PIXELS_X - 1);
  localparam logic [Y_bits-1:0] LastY = Y_bits'(PIXELS_Y - 1);

  logic [1:0]             state_q, state_d;
  logic [X_bits-1:0]      rd_x_q, rd_x_d;
  logic [Y_bits-1:0]      rd_y_q, rd_y_d;
  // Write stage: one cell in flight between its read and its write-back
  logic                   wr_valid_q, wr_valid_d;
  logic [X_bits-1:0]      wr_x_q, wr_x_d;
  logic [Y_bits-1:0]      wr_y_q, wr_y_d;
  logic [SIGNAL_bits-1:0] wr_sig_q, wr_sig_d;
  logic                   wr_sugar_q, wr_sugar_d;
  logic [SIGNAL_bits-1:0] decayed;

  // Compare at 32 bits so a DECAY_AMOUNT wider than the signal still saturates
  always_comb begin
    if (32'(lookup_signal) >= DECAY_AMOUNT) begin
      decayed = lookup_signal - SIGNAL_bits'(DECAY_AMOUNT);
    end else begin
      decayed = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    wr_valid_d = wr_valid_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_sig_d   = wr_sig_q;
    wr_sugar_d = wr_sugar_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSweep;
          rd_x_d     = '0;
          rd_y_d     = '0;
          wr_valid_d = 1'b0;
        end
      end
      StSweep: begin
        if (hold) begin
          // Drop the in-flight cell and re-read it later, so an ant write
          // made during the hold is not clobbered by stale data.
          if (wr_valid_q) begin
            rd_x_d     = wr_x_q;
            rd_y_d     = wr_y_q;
            wr_valid_d = 1'b0;
          end
        end else begin
          wr_valid_d = 1'b1;
          wr_x_d     = rd_x_q;
          wr_y_d     = rd_y_q;
          wr_sig_d   = decayed;
          wr_sugar_d = lookup_sugar;
          if (rd_x_q == LastX) begin
            if (rd_y_q == LastY) begin
              state_d = StDrain;
            end else begin
              rd_x_d = '0;
              rd_y_d = rd_y_q + Y_bits'(1);
            end
          end else begin
            rd_x_d = rd_x_q + X_bits'(1);
          end
        end
      end
      StDrain: begin
        if (hold) begin
          if (wr_valid_q) begin
            rd_x_d     = wr_x_q;
            rd_y_d     = wr_y_q;
            wr_valid_d = 1'b0;
            state_d    = StSweep;
          end
        end else begin
          wr_valid_d = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge newLocClock or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      state_q    <= StIdle;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_sig_q   <= '0;
      wr_sugar_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      wr_valid_q <= wr_valid_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_sig_q   <= wr_sig_d;
      wr_sugar_q <= wr_sugar_d;
    end
  end

  assign busy         = (state_q == StSweep) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign lookup_X     = rd_x_q;
  assign lookup_Y     = rd_y_q;
  assign lookup_en    = (state_q == StSweep) && !hold;
  assign write_X      = wr_x_q;
  assign write_Y      = wr_y_q;
  assign write_en     = busy && wr_valid_q && !hold;
  assign write_signal = wr_sig_q;
  assign write_sugar  = wr_sugar_q;

endmodule

// File: tb/tb_signal_decay_sweeper.sv
// Bench for signal_decay_sweeper on a 4x3 grid with DECAY_AMOUNT=2. It models
// the environment rows as an array, logs every sweeper write, and compares the
// logged writes against tables, hand sequences, and a work-unit timing model.

module tb_signal_decay_sweeper;

  localparam int PX  = 4;
  localparam int PY  = 3;
  localparam int N   = PX * PY;
  localparam int DEC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       busy, done, lookup_en, write_en, write_sugar, lookup_sugar;
  logic [1:0] lookup_X, lookup_Y, write_X, write_Y;
  logic [3:0] lookup_signal, write_signal;

  signal_decay_sweeper #(
    .PIXELS_X    (PX),
    .PIXELS_Y    (PY),
    .X_bits      (2),
    .Y_bits      (2),
    .SIGNAL_bits (4),
    .DECAY_AMOUNT(DEC)
  ) dut (
    .newLocClock  (clk),
    .RESET_SIM    (rst),
    .start        (start),
    .hold         (hold),
    .busy         (busy),
    .done         (done),
    .lookup_X     (lookup_X),
    .lookup_Y     (lookup_Y),
    .lookup_en    (lookup_en),
    .lookup_signal(lookup_signal),
    .lookup_sugar (lookup_sugar),
    .write_X      (write_X),
    .write_Y      (write_Y),
    .write_en     (write_en),
    .write_signal (write_signal),
    .write_sugar  (write_sugar)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    logic [3:0] sig;
    logic       sug;
    int         cyc;
  } wr_t;

  typedef struct {
    logic [3:0] sig_in;
    logic       sug_in;
    logic [3:0] exp_sig;
    logic       exp_sug;
  } vec_t;

  wr_t        wlog[$];
  logic [3:0] mem_sig [0:PY-1][0:PX-1];
  logic       mem_sug [0:PY-1][0:PX-1];
  logic [3:0] init_sig [0:N-1];
  logic       init_sug [0:N-1];
  logic       ld = 1'b0;
  logic       ant_we = 1'b0;
  logic [1:0] ant_x = '0;
  logic [1:0] ant_y = '0;
  logic [3:0] ant_sig = '0;
  int         cyc = 0;
  int         held_writes = 0;
  int         held_lookups = 0;
  int         done_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  assign lookup_signal = (lookup_Y < 2'd3) ? mem_sig[lookup_Y][lookup_X] : 4'd0;
  assign lookup_sugar  = (lookup_Y < 2'd3) ? mem_sug[lookup_Y][lookup_X] : 1'b0;

  // Environment rows plus write/enable monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) begin
      for (int y = 0; y < PY; y++) begin
        for (int x = 0; x < PX; x++) begin
          mem_sig[y][x] <= init_sig[y*PX+x];
          mem_sug[y][x] <= init_sug[y*PX+x];
        end
      end
    end
    if (ant_we) mem_sig[ant_y][ant_x] <= ant_sig;
    if (write_en) begin
      mem_sig[write_Y][write_X] <= write_signal;
      mem_sug[write_Y][write_X] <= write_sugar;
      wlog.push_back('{x: write_X, y: write_Y, sig: write_signal, sug: write_sugar, cyc: cyc});
      if (hold) held_writes <= held_writes + 1;
    end
    if (lookup_en && hold) held_lookups <= held_lookups + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int decay_ref(input int v);
    return (v >= DEC) ? v - DEC : 0;
  endfunction

  function automatic int outs_vec();
    return int'({busy, done, lookup_en, write_en, lookup_X, lookup_Y, write_X, write_Y,
                 write_signal, write_sugar});
  endfunction

  task automatic load_cells();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic load_uniform(input int v);
    for (int i = 0; i < N; i++) begin
      init_sig[i] = 4'(v);
      init_sug[i] = (i == 1*PX + 2);
    end
    load_cells();
  endtask

  // Returns at the negedge of the first cycle after the start edge (cyc == s+1)
  task automatic start_sweep(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int dcyc, output int busy_cnt);
    dcyc = -1;
    busy_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  // Raster order of the N writes starting at base; optional exact cycle check
  task automatic check_order(input string name, input int base, input int s, input bit timed);
    int err = 0;
    for (int i = 0; i < N; i++) begin
      if (base + i >= wlog.size()) begin
        err++;
      end else begin
        if (wlog[base+i].x != 2'(i % PX) || wlog[base+i].y != 2'(i / PX)) err++;
        if (timed && wlog[base+i].cyc != s + 2 + i) err++;
      end
    end
    check(name, err, 0);
  endtask

  task automatic check_uniform(input string name, input int v);
    int err = 0;
    for (int y = 0; y < PY; y++)
      for (int x = 0; x < PX; x++)
        if (int'(mem_sig[y][x]) != v) err++;
    check(name, err, 0);
  endtask

  vec_t tbl [0:N-1];
  int   s, dcyc, bc, base, d0, hw0, hl0, cnt, err, exp_done, units;
  bit   prev;
  bit   pat [0:99];

  initial begin
    tbl[0]  = '{4'd0,  1'b0, 4'd0,  1'b0};
    tbl[1]  = '{4'd1,  1'b1, 4'd0,  1'b1};
    tbl[2]  = '{4'd2,  1'b0, 4'd0,  1'b0};
    tbl[3]  = '{4'd15, 1'b1, 4'd13, 1'b1};
    tbl[4]  = '{4'd5,  1'b0, 4'd3,  1'b0};
    tbl[5]  = '{4'd3,  1'b1, 4'd1,  1'b1};
    tbl[6]  = '{4'd14, 1'b0, 4'd12, 1'b0};
    tbl[7]  = '{4'd7,  1'b1, 4'd5,  1'b1};
    tbl[8]  = '{4'd8,  1'b0, 4'd6,  1'b0};
    tbl[9]  = '{4'd2,  1'b1, 4'd0,  1'b1};
    tbl[10] = '{4'd10, 1'b0, 4'd8,  1'b0};
    tbl[11] = '{4'd4,  1'b1, 4'd2,  1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_vec(), 0);

    // Basic sweep
    load_uniform(5);
    base = wlog.size();
    d0 = done_cnt;
    start_sweep(s);
    wait_done(100, dcyc, bc);
    check("basic_done_cycle", dcyc - s, N + 2);
    check("basic_busy_cycles", bc, N + 1);
    repeat (2) @(negedge clk);
    check("basic_write_count", wlog.size() - base, N);
    check_order("basic_order_timing", base, s, 1'b1);
    check_uniform("basic_values", 3);
    check("basic_sugar_2_1", int'(mem_sug[1][2]), 1);
    check("basic_sugar_0_0", int'(mem_sug[0][0]), 0);
    check("basic_done_pulses", done_cnt - d0, 1);

    // Saturation table
    for (int i = 0; i < N; i++) begin
      init_sig[i] = tbl[i].sig_in;
      init_sug[i] = tbl[i].sug_in;
    end
    load_cells();
    base = wlog.size();
    start_sweep(s);
    wait_done(100, dcyc, bc);
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("tbl_sig_cell%0d", i), int'(mem_sig[i/PX][i%PX]), int'(tbl[i].exp_sig));
      check($sformatf("tbl_sug_cell%0d", i), int'(mem_sug[i/PX][i%PX]), int'(tbl[i].exp_sug));
    end
    check_order("tbl_order_timing", base, s, 1'b1);

    // Hold mid-sweep while the stage holds (1,0), with an ant write of 9
    load_uniform(5);
    base = wlog.size();
    hw0 = held_writes;
    hl0 = held_lookups;
    start_sweep(s);
    goto_cyc(s + 3);
    hold = 1'b1;
    goto_cyc(s + 4);
    ant_x = 2'd1;
    ant_y = 2'd0;
    ant_sig = 4'd9;
    ant_we = 1'b1;
    goto_cyc(s + 5);
    ant_we = 1'b0;
    goto_cyc(s + 6);
    hold = 1'b0;
    wait_done(100, dcyc, bc);
    repeat (2) @(negedge clk);
    check("hold_done_cycle", dcyc - s, N + 2 + 4);
    check("hold_no_writes", held_writes - hw0, 0);
    check("hold_no_lookups", held_lookups - hl0, 0);
    check("hold_cell_1_0", int'(mem_sig[0][1]), 7);
    check("hold_cell_2_0", int'(mem_sig[0][2]), 3);
    check("hold_write_count", wlog.size() - base, N);
    check_order("hold_order", base, s, 1'b0);

    // Hold during the drain write
    load_uniform(5);
    base = wlog.size();
    start_sweep(s);
    goto_cyc(s + N + 1);
    hold = 1'b1;
    goto_cyc(s + N + 2);
    hold = 1'b0;
    wait_done(100, dcyc, bc);
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = base; i < wlog.size(); i++)
      if (wlog[i].x == 2'd3 && wlog[i].y == 2'd2) cnt++;
    check("drain_last_writes", cnt, 1);
    check("drain_last_cycle", wlog[wlog.size()-1].cyc - s, N + 3);
    check("drain_done_cycle", dcyc - s, N + 4);
    check("drain_cell_3_2", int'(mem_sig[2][3]), 3);

    // Start while busy and in DONE
    load_uniform(5);
    base = wlog.size();
    d0 = done_cnt;
    start_sweep(s);
    goto_cyc(s + 5);
    start = 1'b1;
    goto_cyc(s + 6);
    start = 1'b0;
    wait_done(100, dcyc, bc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("restart_done_cycle", dcyc - s, N + 2);
    check("restart_done_pulses", done_cnt - d0, 1);
    check("restart_write_count", wlog.size() - base, N);
    check("restart_busy_after", int'(busy), 0);
    check_uniform("restart_values", 3);

    // Asynchronous reset mid-sweep
    load_uniform(5);
    base = wlog.size();
    d0 = done_cnt;
    start_sweep(s);
    goto_cyc(s + 6);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_outputs", outs_vec(), 0);
    @(negedge clk);
    check("midreset_outputs_held", outs_vec(), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_writes", wlog.size() - base, 4);
    check("midreset_no_done", done_cnt - d0, 0);
    load_uniform(5);
    base = wlog.size();
    start_sweep(s);
    wait_done(100, dcyc, bc);
    repeat (2) @(negedge clk);
    check("postreset_done_cycle", dcyc - s, N + 2);
    check_order("postreset_order_timing", base, s, 1'b1);
    check_uniform("postreset_values", 3);

    // Randomized sweeps with random hold patterns
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++) begin
        init_sig[i] = 4'($urandom_range(0, 15));
        init_sug[i] = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 100; c++) pat[c] = (c >= 1 && c < 90) && ($urandom_range(0, 3) == 0);
      // Sweep = N reads + 1 drain write; a hold right after a productive busy
      // cycle costs one extra re-read.
      units = N + 1;
      prev = 1'b0;
      exp_done = 1;
      while (units > 0) begin
        if (pat[exp_done]) begin
          if (prev) units++;
          prev = 1'b0;
        end else begin
          units--;
          prev = 1'b1;
        end
        exp_done++;
      end
      load_cells();
      base = wlog.size();
      hw0 = held_writes;
      start_sweep(s);
      dcyc = -1;
      for (int c = 1; c < 200; c++) begin
        if (done) begin
          dcyc = cyc;
          break;
        end
        hold = (c < 100) ? pat[c] : 1'b0;
        @(negedge clk);
      end
      hold = 1'b0;
      repeat (2) @(negedge clk);
      err = 0;
      for (int i = 0; i < N; i++) begin
        if (int'(mem_sig[i/PX][i%PX]) != decay_ref(int'(init_sig[i]))) err++;
        if (mem_sug[i/PX][i%PX] != init_sug[i]) err++;
      end
      check($sformatf("rand%0d_values", it), err, 0);
      check($sformatf("rand%0d_done_cycle", it), dcyc - s, exp_done);
      check($sformatf("rand%0d_write_count", it), wlog.size() - base, N);
      check($sformatf("rand%0d_held_writes", it), held_writes - hw0, 0);
      check_order($sformatf("rand%0d_order", it), base, s, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
